// File: rtl/irq_priority_ctrl_if.sv
// Bus between the MIPS core/register host and the interrupt controller.
// The master side is the core and the software register port. The slave
// side is the controller.
interface irq_priority_ctrl_if;
  logic [3:0]  done;
  logic        int_ack;
  logic        eoi;
  logic        irq;
  logic [31:0] int_addr;
  logic [1:0]  int_id;
  logic        in_service;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [3:0]  reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output done, int_ack, eoi, reg_we, reg_addr, reg_wdata,
    input  irq, int_addr, int_id, in_service, reg_rdata
  );

  modport slave (
    input  done, int_ack, eoi, reg_we, reg_addr, reg_wdata,
    output irq, int_addr, int_id, in_service, reg_rdata
  );
endinterface

// File: rtl/irq_priority_ctrl.sv
// Interrupt controller for four accelerator completion lines feeding a
// single-cycle MIPS core. Rising edges of done[] set sticky pending bits.
// A software mask gates them. One source is requested at a time and tracked
// until the ISR's jepc (eoi), so ISRs never nest.
// Optional build macro: ROUND_ROBIN_EN selects rotating priority. When it is
// undefined, the lowest index wins.
// STATUS state encoding: IDLE=0, REQ=1, SERV=2.
module irq_priority_ctrl #(
  parameter logic [31:0] VEC_BASE = 32'h0000_01F0,
  parameter int          NSRC     = 4
) (
  input  logic          Clk,
  input  logic          reset,
  irq_priority_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  done_q;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  rise;
  logic [3:0]  eligible;
  logic [3:0]  w1c_clr;
  logic [3:0]  ack_clr;
  logic        irq_q;
  logic [31:0] int_addr_q;
  logic [1:0]  int_id_q;
  logic        in_service_q;
  logic [1:0]  winner;
  logic        ack_take;
  logic        withdraw;

  assign rise     = bus.done & ~done_q;
  assign eligible = pending_q & mask_q;
  assign ack_take = (state_q == REQ) && bus.int_ack;

  // Next pending/mask values. A rising edge beats any clear on the same bit.
  always_comb begin
    w1c_clr   = 4'h0;
    ack_clr   = 4'h0;
    mask_d    = mask_q;
    if (bus.reg_we && bus.reg_addr == 2'd0) w1c_clr = bus.reg_wdata;
    if (bus.reg_we && bus.reg_addr == 2'd1) mask_d = bus.reg_wdata;
    if (ack_take) ack_clr = 4'b0001 << int_id_q;
    pending_d = (pending_q & ~(w1c_clr | ack_clr)) | rise;
  end

  // The request is withdrawn when its source is no longer pending or enabled,
  // unless the core is acknowledging it in the same cycle.
  assign withdraw = (state_q == REQ) && !bus.int_ack &&
                    (!pending_d[int_id_q] || !mask_d[int_id_q]);

`ifdef ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q;

  // Rotating priority: the first eligible source at or above rr_ptr wins, wrapping 3 to 0.
  always_comb begin
    winner = rr_ptr_q;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (eligible[rr_ptr_q + 2'(k)]) winner = rr_ptr_q + 2'(k);
    end
  end

  // The source just acknowledged drops to the lowest priority.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) rr_ptr_q <= 2'd0;
    else if (ack_take) rr_ptr_q <= int_id_q + 2'd1;
  end
`else
  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    winner = 2'd0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (eligible[k]) winner = 2'(k);
    end
  end
`endif

  // Edge-detect history, sticky pending bits and the software mask.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      done_q    <= 4'h0;
      pending_q <= 4'h0;
      mask_q    <= 4'hF;
    end else begin
      done_q    <= bus.done;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // Request/service state machine with registered core-facing outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_q        <= 1'b0;
      int_addr_q   <= 32'h0;
      int_id_q     <= 2'd0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            int_id_q   <= winner;
            irq_q      <= 1'b1;
            int_addr_q <= VEC_BASE + {28'd0, winner, 2'b00};
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (ack_take) begin
            irq_q        <= 1'b0;
            int_addr_q   <= 32'h0;
            in_service_q <= 1'b1;
            state_q      <= SERV;
          end else if (withdraw) begin
            irq_q      <= 1'b0;
            int_addr_q <= 32'h0;
            state_q    <= IDLE;
          end
        end
        SERV: begin
          if (bus.eoi) begin
            in_service_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Combinational register read-back, zero-extended to the bus width.
  always_comb begin
    case (bus.reg_addr)
      2'd0:    bus.reg_rdata = {28'd0, pending_q};
      2'd1:    bus.reg_rdata = {28'd0, mask_q};
      2'd2:    bus.reg_rdata = {27'd0, state_q, in_service_q, int_id_q};
      default: bus.reg_rdata = 32'h0;
    endcase
  end

  assign bus.irq        = irq_q;
  assign bus.int_addr   = int_addr_q;
  assign bus.int_id     = int_id_q;
  assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Testbench for irq_priority_ctrl. Directed scenarios from the test plan,
// followed by a randomized run checked against a behavioural model.
// Build with ROUND_ROBIN_EN to exercise rotating priority.
module tb_irq_priority_ctrl;
  localparam logic [31:0] VEC_BASE = 32'h0000_01F0;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SERV = 2;

  logic Clk = 1'b0;
  logic reset;
  irq_priority_ctrl_if bus();

  irq_priority_ctrl #(.VEC_BASE(VEC_BASE), .NSRC(4)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit [3:0]  mPending, mMask, mLastDone;
  int        mPhase;
  bit        mIrq, mInServ;
  bit [31:0] mAddr;
  bit [1:0]  mId;
  int        mRr;

  function automatic int pickSource(bit [3:0] elig);
    int s;
    for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
      s = (mRr + k) % 4;
`else
      s = k;
`endif
      if (elig[s]) return s;
    end
    return -1;
  endfunction

  function automatic bit [31:0] modelRead(bit [1:0] a);
    case (a)
      2'd0:    return {28'd0, mPending};
      2'd1:    return {28'd0, mMask};
      2'd2:    return 32'(mPhase * 8 + (mInServ ? 4 : 0) + int'(mId));
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelInit();
    mPending = 4'h0; mMask = 4'hF; mLastDone = 4'h0; mPhase = P_IDLE;
    mIrq = 1'b0; mInServ = 1'b0; mAddr = 32'h0; mId = 2'd0; mRr = 0;
  endtask

  // Applies the current inputs to the model, then advances to just past the next edge.
  task automatic stepClock();
    bit [3:0] rise, nPend, nMask, after;
    int pick;
    rise  = bus.done & ~mLastDone;
    nPend = mPending;
    nMask = mMask;
    if (bus.reg_we && bus.reg_addr == 2'd1) nMask = bus.reg_wdata;
    if (bus.reg_we && bus.reg_addr == 2'd0) nPend = nPend & ~bus.reg_wdata;
    case (mPhase)
      P_IDLE: begin
        pick = pickSource(mPending & mMask);
        if (pick >= 0) begin
          mId = 2'(pick); mIrq = 1'b1; mAddr = VEC_BASE + 32'(4 * pick); mPhase = P_REQ;
        end
      end
      P_REQ: begin
        after = nPend | rise;
        if (bus.int_ack) begin
          nPend[mId] = 1'b0; mIrq = 1'b0; mAddr = 32'h0; mInServ = 1'b1;
          mPhase = P_SERV; mRr = (int'(mId) + 1) % 4;
        end else if (!after[mId] || !nMask[mId]) begin
          mIrq = 1'b0; mAddr = 32'h0; mPhase = P_IDLE;
        end
      end
      default: begin
        if (bus.eoi) begin
          mInServ = 1'b0; mPhase = P_IDLE;
        end
      end
    endcase
    nPend     = nPend | rise;
    mLastDone = bus.done;
    @(posedge Clk);
    #1;
    mPending = nPend;
    mMask    = nMask;
  endtask

  task automatic doReset();
    @(negedge Clk);
    reset = 1'b1;
    bus.done = 4'h0; bus.int_ack = 1'b0; bus.eoi = 1'b0;
    bus.reg_we = 1'b0; bus.reg_addr = 2'd0; bus.reg_wdata = 4'h0;
    modelInit();
    repeat (2) @(negedge Clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b want 0", bus.irq); end
    checks++; if (bus.int_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.int_addr); end
    checks++; if (bus.int_id !== 2'd0 || bus.in_service !== 1'b0) begin errors++; $display("FAIL reset_id_serv: got %0d/%0b want 0/0", bus.int_id, bus.in_service); end
    bus.reg_addr = 2'd0; #1;
    checks++; if (bus.reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h want 0", bus.reg_rdata); end
    bus.reg_addr = 2'd1; #1;
    checks++; if (bus.reg_rdata !== 32'hF) begin errors++; $display("FAIL reset_mask: got %h want F", bus.reg_rdata); end
    bus.reg_addr = 2'd2; #1;
    checks++; if (bus.reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", bus.reg_rdata); end
  endtask

  task automatic test_single_event();
    logic [31:0] st;
    doReset();
    bus.done = 4'b0010;
    stepClock();
    bus.reg_addr = 2'd0; #1;
    checks++; if (bus.reg_rdata !== 32'h2 || bus.irq !== 1'b0) begin errors++; $display("FAIL single_pending: got %h irq %0b want 2 irq 0", bus.reg_rdata, bus.irq); end
    stepClock();
    checks++; if (bus.irq !== 1'b1 || bus.int_id !== 2'd1 || bus.int_addr !== 32'h1F4) begin errors++; $display("FAIL single_req: got irq %0b id %0d addr %h want 1 1 1F4", bus.irq, bus.int_id, bus.int_addr); end
    bus.int_ack = 1'b1;
    stepClock();
    bus.int_ack = 1'b0;
    #1;
    checks++; if (bus.irq !== 1'b0 || bus.in_service !== 1'b1 || bus.reg_rdata !== 32'h0) begin errors++; $display("FAIL single_ack: got irq %0b serv %0b pend %h want 0 1 0", bus.irq, bus.in_service, bus.reg_rdata); end
    bus.eoi = 1'b1;
    stepClock();
    bus.eoi = 1'b0;
    bus.reg_addr = 2'd2; #1;
    st = bus.reg_rdata;
    checks++; if (st[4:2] !== 3'b000) begin errors++; $display("FAIL single_eoi_status: got state/serv %b want 000", st[4:2]); end
    bus.done = 4'h0;
  endtask

  task automatic test_simultaneous();
    doReset();
    bus.done = 4'b1010;
    stepClock();
    stepClock();
    checks++; if (bus.int_addr !== 32'h1F4) begin errors++; $display("FAIL simul_first: got %h want 1F4", bus.int_addr); end
    bus.int_ack = 1'b1; stepClock(); bus.int_ack = 1'b0;
    bus.eoi = 1'b1; stepClock(); bus.eoi = 1'b0;
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL simul_eoi_irq: got %0b want 0", bus.irq); end
    stepClock();
    checks++; if (bus.irq !== 1'b1 || bus.int_addr !== 32'h1FC) begin errors++; $display("FAIL simul_second: got irq %0b addr %h want 1 1FC", bus.irq, bus.int_addr); end
    bus.int_ack = 1'b1; stepClock(); bus.int_ack = 1'b0;
    bus.eoi = 1'b1; stepClock(); bus.eoi = 1'b0;
    bus.done = 4'h0;
  endtask

  task automatic test_mask();
    doReset();
    bus.reg_we = 1'b1; bus.reg_addr = 2'd1; bus.reg_wdata = 4'b1110;
    stepClock();
    bus.reg_we = 1'b0;
    bus.done = 4'b0001;
    stepClock();
    bus.reg_addr = 2'd0; #1;
    checks++; if (bus.reg_rdata !== 32'h1) begin errors++; $display("FAIL mask_pending: got %h want 1", bus.reg_rdata); end
    stepClock(); stepClock();
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL mask_blocked: got irq %0b want 0", bus.irq); end
    bus.reg_we = 1'b1; bus.reg_addr = 2'd1; bus.reg_wdata = 4'hF;
    stepClock();
    bus.reg_we = 1'b0;
    stepClock();
    checks++; if (bus.irq !== 1'b1 || bus.int_addr !== 32'h1F0) begin errors++; $display("FAIL mask_release: got irq %0b addr %h want 1 1F0", bus.irq, bus.int_addr); end
    bus.done = 4'h0;
  endtask

  task automatic test_withdraw();
    logic [31:0] st;
    doReset();
    bus.done = 4'b0100;
    stepClock(); stepClock();
    checks++; if (bus.irq !== 1'b1 || bus.int_id !== 2'd2) begin errors++; $display("FAIL withdraw_req: got irq %0b id %0d want 1 2", bus.irq, bus.int_id); end
    bus.reg_we = 1'b1; bus.reg_addr = 2'd0; bus.reg_wdata = 4'b0100;
    stepClock();
    bus.reg_we = 1'b0;
    bus.reg_addr = 2'd2; #1;
    st = bus.reg_rdata;
    checks++; if (bus.irq !== 1'b0 || bus.int_addr !== 32'h0 || st[4:3] !== 2'd0) begin errors++; $display("FAIL withdraw: got irq %0b addr %h state %0d want 0 0 0", bus.irq, bus.int_addr, st[4:3]); end
    bus.done = 4'h0;
  endtask

  task automatic test_collision();
    doReset();
    bus.done = 4'b1000;
    bus.reg_we = 1'b1; bus.reg_addr = 2'd0; bus.reg_wdata = 4'b1000;
    stepClock();
    bus.reg_we = 1'b0; #1;
    checks++; if (bus.reg_rdata !== 32'h8) begin errors++; $display("FAIL collision_set_wins: got %h want 8", bus.reg_rdata); end
    bus.done = 4'h0;
  endtask

  task automatic test_held_level();
    int services = 0;
    doReset();
    bus.done = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      bus.int_ack = bus.irq;
      bus.eoi     = bus.in_service;
      if (bus.int_ack && bus.irq) services++;
      stepClock();
    end
    bus.int_ack = 1'b0; bus.eoi = 1'b0;
    checks++; if (services !== 1 || bus.irq !== 1'b0) begin errors++; $display("FAIL held_level: got %0d services irq %0b want 1 0", services, bus.irq); end
    bus.done = 4'h0;
  endtask

  task automatic test_reset_mid_service();
    doReset();
    bus.done = 4'b0100;
    stepClock(); stepClock();
    bus.int_ack = 1'b1; stepClock(); bus.int_ack = 1'b0;
    checks++; if (bus.in_service !== 1'b1) begin errors++; $display("FAIL midreset_setup: got serv %0b want 1", bus.in_service); end
    bus.reg_we = 1'b1; bus.reg_addr = 2'd1; bus.reg_wdata = 4'b0011;
    stepClock();
    bus.reg_we = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.in_service !== 1'b0 || bus.irq !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got serv %0b irq %0b want 0 0", bus.in_service, bus.irq); end
    bus.reg_addr = 2'd1; #1;
    checks++; if (bus.reg_rdata !== 32'hF) begin errors++; $display("FAIL midreset_mask: got %h want F", bus.reg_rdata); end
    bus.reg_addr = 2'd0; #1;
    checks++; if (bus.reg_rdata !== 32'h0) begin errors++; $display("FAIL midreset_pending: got %h want 0", bus.reg_rdata); end
    bus.done = 4'h0;
    @(negedge Clk);
    modelInit();
    reset = 1'b0;
  endtask

`ifdef ROUND_ROBIN_EN
  task automatic test_round_robin();
    int order[4];
    int n = 0;
    doReset();
    for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
      bus.done    = (cyc % 2 == 0) ? 4'b0011 : 4'b0000;
      bus.int_ack = bus.irq;
      bus.eoi     = bus.in_service;
      if (bus.int_ack && bus.irq) begin
        order[n] = int'(bus.int_id);
        n++;
      end
      stepClock();
    end
    bus.done = 4'h0; bus.int_ack = 1'b0; bus.eoi = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL rr_count: got %0d services want 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (order[i] != (i % 2)) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
    end
  endtask
`endif

  task automatic test_random();
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 3) == 0) bus.done = bus.done ^ 4'($urandom_range(0, 15));
      bus.int_ack = bus.irq ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      bus.eoi     = bus.in_service ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      bus.reg_we  = ($urandom_range(0, 9) == 0);
      bus.reg_addr  = 2'($urandom_range(0, 3));
      bus.reg_wdata = (bus.reg_addr == 2'd1 && $urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      stepClock();
      checks++; if (bus.irq !== mIrq) begin errors++; $display("FAIL rand_irq @%0d: got %0b want %0b", cyc, bus.irq, mIrq); end
      checks++; if (bus.int_addr !== mAddr) begin errors++; $display("FAIL rand_addr @%0d: got %h want %h", cyc, bus.int_addr, mAddr); end
      checks++; if (bus.int_id !== mId) begin errors++; $display("FAIL rand_id @%0d: got %0d want %0d", cyc, bus.int_id, mId); end
      checks++; if (bus.in_service !== mInServ) begin errors++; $display("FAIL rand_serv @%0d: got %0b want %0b", cyc, bus.in_service, mInServ); end
      checks++; if (bus.reg_rdata !== modelRead(bus.reg_addr)) begin errors++; $display("FAIL rand_rdata @%0d addr %0d: got %h want %h", cyc, bus.reg_addr, bus.reg_rdata, modelRead(bus.reg_addr)); end
    end
    bus.reg_we = 1'b0; bus.int_ack = 1'b0; bus.eoi = 1'b0; bus.done = 4'h0;
  endtask

  initial begin
    reset = 1'b1;
    bus.done = 4'h0; bus.int_ack = 1'b0; bus.eoi = 1'b0;
    bus.reg_we = 1'b0; bus.reg_addr = 2'd0; bus.reg_wdata = 4'h0;
    modelInit();
    test_reset();
    test_single_event();
    test_simultaneous();
    test_mask();
    test_withdraw();
    test_collision();
    test_held_level();
    test_reset_mid_service();
`ifdef ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_priority_ctrl.md
Name: irq_priority_ctrl

Overview:
- Interrupt controller between the four accelerator completion lines (done[3:0]) and the single-cycle MIPS core.
- Captures completion events as sticky pending bits, applies a software mask, and picks one source by priority.
- Drives the core's interrupt request and supplies the vector address that the core loads into PC on acknowledge.
- Tracks the in-service source until the ISR's jepc returns, so only one ISR runs at a time (no nesting).

Parameters:
- VEC_BASE, 32'h0000_01F0: byte address of the vector for source 0; source n vectors to VEC_BASE + 4*n (imem words 124..127).
- NSRC, 4: number of sources; the design is only required to be correct at 4.

Ports:
- Clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- done  in  4  accelerator completion levels; bit 0 = done1.
- int_ack  in  1  core accepted the vector this cycle; single-cycle pulse.
- eoi  in  1  end of interrupt; pulse when jepc executes.
- irq  out  1  interrupt request to the core; registered.
- int_addr  out  32  vector address; valid while irq=1, otherwise 0.
- int_id  out  2  index of the requested or in-service source.
- in_service  out  1  high from the int_ack cycle until eoi.
- reg_we  in  1  register write strobe.
- reg_addr  in  2  register select.
- reg_wdata  in  4  register write data.
- reg_rdata  out  32  register read data, combinational, zero-extended.

Behaviour:
- Reset values: irq=0, int_addr=0, int_id=0, in_service=0, pending=4'h0, mask=4'hF, done_q=0, state=IDLE, rr_ptr=0.
- Reset asserted mid-operation aborts any request or service immediately. The core does not get an eoi for it.
- Edge detection:
  - done_q <= done every cycle; rise = done & ~done_q.
  - pending |= rise on the next edge, so pending is visible 1 cycle after done rises.
  - A level held high sets pending only once per rising edge.
- Registers (writes apply on the Clk edge):
  - addr 0 PENDING: read pending; write 1 to clear. If a rise and a clear hit the same bit in the same cycle, the set wins.
  - addr 1 MASK: read/write; 1 = enabled.
  - addr 2 STATUS: read {27'b0, state[1:0], in_service, int_id}; writes ignored.
  - addr 3: reads 0; writes ignored.
- eligible = pending & mask.
- Fixed priority: lowest index wins (done1 highest).
- FSM:
  - IDLE:
    - If eligible != 0: latch int_id = winner; irq <= 1; int_addr <= VEC_BASE + {int_id,2'b00}; go to REQ.
    - Latency: done rise to irq high = 2 cycles.
  - REQ:
    - int_ack=1: clear pending[int_id]; irq <= 0; int_addr <= 0; in_service <= 1; go to SERV.
    - Otherwise, if pending[int_id] is cleared by W1C or mask[int_id] goes to 0: withdraw (irq <= 0, int_addr <= 0) and go to IDLE. int_ack takes precedence over withdrawal in the same cycle.
    - A higher-priority source arriving during REQ does not preempt; int_id stays latched.
  - SERV:
    - eoi=1: in_service <= 0; go to IDLE.
    - New events keep accumulating in pending.
    - Back-to-back: the next irq rises 1 cycle after eoi if eligible != 0.
- int_ack or eoi arriving outside REQ or SERV respectively is ignored.
- If the same source fires again while in service, pending is set again and that source is serviced after eoi.

Optional Feature:
- ROUND_ROBIN_EN defined:
  - Winner = first eligible bit scanning upward from rr_ptr, wrapping 3 to 0.
  - On int_ack, rr_ptr <= int_id + 1 (mod 4).
- Not defined: fixed priority as above; rr_ptr is not implemented.

Test Plan:
- Single event: reset, then done=4'b0010 → pending=4'b0010 after 1 cycle; irq=1, int_id=1, int_addr=32'h1F4 after 2 cycles; int_ack pulse → irq=0, in_service=1, pending=0; eoi → STATUS state=IDLE.
- Simultaneous: done=4'b1010 → int_addr=32'h1F4 first. After int_ack and eoi, irq reasserts 1 cycle later with int_addr=32'h1FC.
- Mask: MASK=4'b1110, then done1 rises → pending=4'b0001, irq stays 0. Write MASK=4'hF → irq=1 with int_addr=32'h1F0 two cycles later.
- Withdraw and collision:
  - In REQ for source 2, W1C PENDING=4'b0100 → irq=0 next cycle, state=IDLE.
  - Separately: a W1C of bit 3 in the same cycle as a done4 rise → pending[3] stays 1.
- Held level and reset: hold done[0]=1 for 10 cycles → exactly one service. Assert reset during SERV → in_service=0, mask=4'hF, pending=0 at once.
- With ROUND_ROBIN_EN: keep done[0] and done[1] re-firing → service order alternates 0,1,0,1.
